// File: rtl/alu_writeback_regfile.sv
// alu_writeback_regfile - MIPS register file with ALU writeback stage, overflow trap and counters.
module alu_writeback_regfile #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      rd_instr,
  output logic [31:0]      regA,
  output logic [31:0]      regB,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [31:0]      result,
  input  logic [2:0]       flags,
  output logic             exc_valid,
  output logic [31:0]      exc_instr,
  input  logic             exc_ack,
  output logic [2:0]       sticky_flags,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic [4:0]       dbg_addr,
  output logic [31:0]      dbg_data
);

  typedef enum logic {RUN, EXC} state_t;

  state_t      state;
  logic [31:0] regs [32];
  logic        stg_valid;
  logic [4:0]  stg_dest;
  logic [31:0] stg_data;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        is_r;
  logic [4:0]  dest;
  logic        trap_op;
  logic        non_wr;
  logic        accept;
  logic        trap;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        unused_bits;

  assign unused_bits = ^{rd_instr[15:0], instruction[25:21], instruction[10:6]};

  assign opcode  = instruction[31:26];
  assign funct   = instruction[5:0];
  assign is_r    = (opcode == 6'b000000);
  assign dest    = is_r ? instruction[15:11] : instruction[20:16];
  assign trap_op = is_r ? (funct == 6'b100000 || funct == 6'b100010)
                        : (opcode == 6'b001000);
  assign non_wr  = (opcode == 6'b000100) || (opcode == 6'b000101) ||
                   (opcode == 6'b101011) || (opcode == 6'b100011) ||
                   (is_r && funct == 6'b001000);

  assign in_ready  = (state == RUN);
  assign exc_valid = (state == EXC);
  assign accept    = in_valid && in_ready;
  assign trap      = accept && trap_op && flags[0];

  assign rs = rd_instr[25:21];
  assign rt = rd_instr[20:16];

  // A pending stage write is newer than the array contents, so it wins.
  always_comb begin
    regA = 32'd0;
    regB = 32'd0;
    if (rs != 5'd0) regA = (stg_valid && stg_dest == rs) ? stg_data : regs[rs];
    if (rt != 5'd0) regB = (stg_valid && stg_dest == rt) ? stg_data : regs[rt];
  end

  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      state        <= RUN;
      stg_valid    <= 1'b0;
      stg_dest     <= 5'd0;
      stg_data     <= 32'd0;
      exc_instr    <= 32'd0;
      sticky_flags <= 3'd0;
      retired_cnt  <= '0;
      ovf_cnt      <= '0;
    end else begin
      if (stg_valid) regs[stg_dest] <= stg_data;

      stg_valid <= 1'b0;
      if (trap) begin
        state     <= EXC;
        exc_instr <= instruction;
        ovf_cnt   <= ovf_cnt + 1'b1;
      end else if (accept) begin
        retired_cnt  <= retired_cnt + 1'b1;
        sticky_flags <= sticky_flags | flags;
        if (!non_wr && dest != 5'd0) begin
          stg_valid <= 1'b1;
          stg_dest  <= dest;
          stg_data  <= result;
        end
      end

      if (state == EXC && exc_ack) begin
        state     <= RUN;
        exc_instr <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback_regfile.sv
// tb/tb_alu_writeback_regfile.sv - directed-vector bench for alu_writeback_regfile.
module tb_alu_writeback_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rd_instr;
  logic [31:0] regA, regB;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction, result;
  logic [2:0]  flags;
  logic        exc_valid;
  logic [31:0] exc_instr;
  logic        exc_ack;
  logic [2:0]  sticky_flags;
  logic [31:0] retired_cnt, ovf_cnt;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int vectors = 0;
  int miscompares = 0;

  alu_writeback_regfile #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .rd_instr(rd_instr), .regA(regA), .regB(regB),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .result(result), .flags(flags), .exc_valid(exc_valid), .exc_instr(exc_instr),
    .exc_ack(exc_ack), .sticky_flags(sticky_flags), .retired_cnt(retired_cnt),
    .ovf_cnt(ovf_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bundle(input logic [31:0] ins, input logic [31:0] res, input logic [2:0] fl);
    in_valid = 1'b1; instruction = ins; result = res; flags = fl;
  endtask

  initial begin
    reset = 1'b1; rd_instr = 32'd0; in_valid = 1'b0; instruction = 32'd0;
    result = 32'd0; flags = 3'd0; exc_ack = 1'b0; dbg_addr = 5'd0;
    step(); step();
    reset = 1'b0; #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
    check("rst_exc_instr", exc_instr, 32'd0);
    check("rst_sticky", {29'd0, sticky_flags}, 32'd0);
    check("rst_retired", retired_cnt, 32'd0);
    check("rst_ovf", ovf_cnt, 32'd0);

    // 1: addu to $0 retires but writes nothing
    bundle(32'h00010021, 32'hFFFFFFFF, 3'b000);
    step(); in_valid = 1'b0;
    check("t1_retired", retired_cnt, 32'd1);
    step();
    dbg_addr = 5'd0; #1;
    check("t1_dbg0", dbg_data, 32'd0);
    dbg_addr = 5'd1; #1;
    check("t1_dbg1", dbg_data, 32'd0);
    check("t1_sticky", {29'd0, sticky_flags}, 32'd0);

    // 2: addiu to $1; exc_ack in RUN is ignored
    bundle(32'h24017FFF, 32'h80007FFE, 3'b010);
    exc_ack = 1'b1;
    step(); in_valid = 1'b0; exc_ack = 1'b0;
    rd_instr = 32'h00200000; dbg_addr = 5'd1; #1;
    check("t2_dbg_before_commit", dbg_data, 32'd0);
    check("t2_regA_bypass", regA, 32'h80007FFE);
    check("t2_ack_in_run", {31'd0, in_ready}, 32'd1);
    step();
    check("t2_dbg_commit", dbg_data, 32'h80007FFE);
    check("t2_sticky", {29'd0, sticky_flags}, 32'h2);
    check("t2_retired", retired_cnt, 32'd2);

    // 3: add rd=3 with overflow traps; bundles offered in EXC are not taken
    bundle(32'h00211820, 32'h12345678, 3'b001);
    step();
    bundle(32'h00001821, 32'h0000DEAD, 3'b000);
    dbg_addr = 5'd3; #1;
    check("t3_exc_valid", {31'd0, exc_valid}, 32'd1);
    check("t3_in_ready", {31'd0, in_ready}, 32'd0);
    check("t3_exc_instr", exc_instr, 32'h00211820);
    check("t3_ovf", ovf_cnt, 32'd1);
    check("t3_sticky", {29'd0, sticky_flags}, 32'h2);
    step();
    check("t3_retired_held", retired_cnt, 32'd2);
    check("t3_dbg3", dbg_data, 32'd0);
    in_valid = 1'b0; exc_ack = 1'b1;
    step(); exc_ack = 1'b0; #1;
    check("t3_exit_valid", {31'd0, exc_valid}, 32'd0);
    check("t3_exit_ready", {31'd0, in_ready}, 32'd1);
    check("t3_exit_instr", exc_instr, 32'd0);
    check("t3_dbg3_after", dbg_data, 32'd0);

    // 4: bypass of a freshly staged $5
    bundle(32'h00002821, 32'h00001234, 3'b000);
    step(); in_valid = 1'b0;
    rd_instr = 32'h00A50000; dbg_addr = 5'd5; #1;
    check("t4_regA_bypass", regA, 32'h1234);
    check("t4_regB_bypass", regB, 32'h1234);
    check("t4_dbg_before", dbg_data, 32'd0);
    step();
    check("t4_regA_file", regA, 32'h1234);
    check("t4_dbg_after", dbg_data, 32'h1234);
    check("t4_retired", retired_cnt, 32'd3);

    // 5: back-to-back writes to $6
    bundle(32'h00003021, 32'h0000000A, 3'b000);
    step();
    result = 32'h0000000B;
    dbg_addr = 5'd6; #1;
    check("t5_dbg_first", dbg_data, 32'd0);
    step(); in_valid = 1'b0;
    rd_instr = 32'h00C00000; #1;
    check("t5_dbg_A", dbg_data, 32'hA);
    check("t5_regA_B", regA, 32'hB);
    step();
    check("t5_dbg_B", dbg_data, 32'hB);
    check("t5_retired", retired_cnt, 32'd5);

    // addu with overflow flag does not trap; sub without overflow retires; beq writes nothing
    bundle(32'h00003821, 32'h00000007, 3'b001);
    step();
    bundle(32'h00004022, 32'h00000042, 3'b100);
    step();
    bundle(32'h10080000, 32'h00000099, 3'b000);
    step(); in_valid = 1'b0;
    step();
    check("x_no_trap", {31'd0, exc_valid}, 32'd0);
    check("x_sticky", {29'd0, sticky_flags}, 32'h7);
    check("x_retired", retired_cnt, 32'd8);
    dbg_addr = 5'd7; #1;
    check("x_dbg7", dbg_data, 32'h7);
    dbg_addr = 5'd8; #1;
    check("x_dbg8_sub", dbg_data, 32'h42);
    rd_instr = 32'h00080000; #1;
    check("x_regB_rt8", regB, 32'h42);

    // 6: staged $9 commits on the trap edge, then reset while in EXC
    bundle(32'h00004821, 32'h00000055, 3'b000);
    step();
    bundle(32'h200A0000, 32'h7FFFFFFF, 3'b001);
    step(); in_valid = 1'b0;
    dbg_addr = 5'd9; #1;
    check("t6_dbg9_commit", dbg_data, 32'h55);
    check("t6_exc", {31'd0, exc_valid}, 32'd1);
    check("t6_ovf", ovf_cnt, 32'd2);
    reset = 1'b1;
    step(); reset = 1'b0; #1;
    check("t6_rst_exc_valid", {31'd0, exc_valid}, 32'd0);
    check("t6_rst_ready", {31'd0, in_ready}, 32'd1);
    check("t6_rst_exc_instr", exc_instr, 32'd0);
    check("t6_rst_retired", retired_cnt, 32'd0);
    check("t6_rst_ovf", ovf_cnt, 32'd0);
    check("t6_rst_sticky", {29'd0, sticky_flags}, 32'd0);
    check("t6_rst_dbg9", dbg_data, 32'd0);

    // reset with a full stage drops the write to $11
    bundle(32'h00005821, 32'h00000077, 3'b000);
    step(); in_valid = 1'b0; reset = 1'b1;
    step(); reset = 1'b0;
    rd_instr = 32'h01600000; dbg_addr = 5'd11; #1;
    check("t6_stage_regA", regA, 32'd0);
    step();
    check("t6_stage_dbg11", dbg_data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
